// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instr in ID.
module hazard_detect #(
    parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable/flush sequencer: load-use stall, branch squash, data-memory freeze.
// Optional STALL_PERF_CNT_EN adds a free-running stall-cycle counter port.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = pipeline_ctrl_pkg::MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  stall,
    output logic                  mem_timeout_err,
    output logic [1:0]            ctrl_state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    import pipeline_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             load_use;
    logic             freeze;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // State changes on the falling edge, in step with the pipeline registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        freeze     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < TIMEOUT_C) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end else begin
                    // Forced release: the pipe runs this cycle and the error latches.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall       = 1'b0;
        if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            stall     = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall       = 1'b1;
        end
    end

    assign mem_timeout_err = err_q;
    assign ctrl_state      = state_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else if (stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: decode table plus freeze/timeout/reset sequences.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
        string      name;
    } vec_t;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, stall}
    localparam logic [7:0] NORM = 8'b11111_00_0;
    localparam logic [7:0] LU   = 8'b00111_01_1;
    localparam logic [7:0] BR   = 8'b11111_11_0;
    localparam logic [7:0] FRZ  = 8'b00000_00_1;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, stall;
    logic        mem_timeout_err;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;
    logic [7:0]  outs;

    int          tests = 0;
    int          fails = 0;
    logic        exp_stall;
    logic [31:0] model_cnt;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (15),
        .CNT_W       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .stall           (stall),
        .mem_timeout_err (mem_timeout_err),
        .ctrl_state      (ctrl_state)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

`ifndef STALL_PERF_CNT_EN
    assign stall_cycles = '0;
`endif

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference stall counter, advanced from the bench's own expected stall bit.
    always @(negedge clk or negedge reset) begin
        if (!reset) model_cnt <= '0;
        else if (exp_stall) model_cnt <= model_cnt + 32'd1;
    end

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic ld, input logic [4:0] rd,
                               input logic br, input logic mreq, input logic mrdy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld;
        v.rd = rd; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        return v;
    endfunction

    task automatic drive(input in_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_mem_read = v.ld; ex_rd = v.rd; ex_branch_taken = v.br;
        mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [7:0] exp, input logic [1:0] exp_st,
                             input logic exp_err);
        check({nm, ".outs"}, {24'd0, outs}, {24'd0, exp});
        check({nm, ".state"}, {30'd0, ctrl_state}, {30'd0, exp_st});
        check({nm, ".err"}, {31'd0, mem_timeout_err}, {31'd0, exp_err});
`ifdef STALL_PERF_CNT_EN
        check({nm, ".stall_cycles"}, stall_cycles, model_cnt);
`endif
    endtask

    // Drive mid-cycle (rising edge), check combinational outputs before the falling edge.
    task automatic step(input in_t v, input logic [7:0] exp, input logic [1:0] exp_st,
                        input logic exp_err, input string nm);
        @(posedge clk);
        drive(v);
        exp_stall = exp[0];
        #1;
        check_all(nm, exp, exp_st, exp_err);
    endtask

    vec_t vecs[11];
    in_t  idle_v, wait_v;

    initial begin
        idle_v = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        wait_v = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        vecs[0]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), NORM, "idle"};
        vecs[1]  = '{mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), LU,   "lu_rs1"};
        vecs[2]  = '{mk(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), LU,   "lu_rs2"};
        vecs[3]  = '{mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), NORM, "x0_load"};
        vecs[4]  = '{mk(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), NORM, "rs2_unused"};
        vecs[5]  = '{mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0), NORM, "non_load"};
        vecs[6]  = '{mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), BR,   "branch_lu"};
        vecs[7]  = '{mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0), BR,   "branch"};
        vecs[8]  = '{mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1), LU,   "lu_mem_ready"};
        vecs[9]  = '{mk(5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), NORM, "rs_mismatch"};
        vecs[10] = '{mk(5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), NORM, "no_use"};

        reset = 1'b0;
        exp_stall = 1'b0;
        drive(idle_v);
        #2;
        check_all("reset", NORM, 2'd0, 1'b0);
        @(posedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].in, vecs[i].exp, 2'd0, 1'b0, $sformatf("vec%0d_%s", i, vecs[i].name));
        end

        // Load-use lasts one cycle: the bubble then sits in EX.
        step(mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), LU, 2'd0, 1'b0, "lu_seq0");
        step(mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), NORM, 2'd0, 1'b0, "lu_seq1");

        // Three-cycle memory wait, hazards ignored while frozen, release on ready.
        step(wait_v, FRZ, 2'd0, 1'b0, "mw1");
        step(mk(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0), FRZ, 2'd1, 1'b0, "mw2_ignore");
        step(wait_v, FRZ, 2'd1, 1'b0, "mw3");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), NORM, 2'd1, 1'b0, "mw_release");
        step(idle_v, NORM, 2'd0, 1'b0, "mw_run");

        // Timeout: 15 frozen cycles, then a forced-release cycle, then sticky error.
        for (int k = 1; k <= 15; k++) begin
            step(wait_v, FRZ, (k == 1) ? 2'd0 : 2'd1, 1'b0, $sformatf("to_frz%0d", k));
        end
        step(wait_v, NORM, 2'd1, 1'b0, "to_release");
        step(idle_v, NORM, 2'd0, 1'b1, "to_err_set");
        step(mk(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), LU, 2'd0, 1'b1, "to_err_lu");
        step(idle_v, NORM, 2'd0, 1'b1, "to_err_sticky");

        // Asynchronous reset in the middle of a memory wait.
        step(wait_v, FRZ, 2'd0, 1'b1, "rst_mw1");
        step(wait_v, FRZ, 2'd1, 1'b1, "rst_mw2");
        step(idle_v, FRZ, 2'd1, 1'b1, "rst_mw3");
        exp_stall = 1'b0;
        reset = 1'b0;
        #1;
        check_all("rst_async", NORM, 2'd0, 1'b0);
        @(posedge clk);
        reset = 1'b1;
        step(idle_v, NORM, 2'd0, 1'b0, "post_rst");
        step(wait_v, FRZ, 2'd0, 1'b0, "post_rst_mw");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), NORM, 2'd1, 1'b0, "post_rst_rel");
        step(idle_v, NORM, 2'd0, 1'b0, "post_rst_run");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
